// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the shared-FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int NREQ_DEF       = 4;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int BURST_DEF      = 4;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request bit at or after (last_grant+1), wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last_grant,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] index
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = IW + 1;

  logic [SW-1:0] cand;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    cand  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last_grant} + SW'(k);
      if (cand >= SW'(NREQ)) cand = cand - SW'(NREQ);
      if (req[cand[IW-1:0]]) begin
        found = 1'b1;
        index = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter funnelling NREQ producers into one shared FIFO write port.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ       = NREQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST      = BURST_DEF
) (
  input  logic                       clock,
  input  logic                       resetn,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DATA_WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      fifo_data_in,
  output logic [$clog2(NREQ)-1:0]    grant_id,
  output logic                       busy
);

  localparam int IW  = $clog2(NREQ);
  localparam int BCW = $clog2(BURST + 1);

  arb_state_t            state, state_nxt;
  logic [IW-1:0]         last_grant;
  logic [BCW-1:0]        beat_cnt;
  logic                  pick_found;
  logic [IW-1:0]         pick_idx;
  logic                  owner_valid;
  logic                  xfer;
  logic                  burst_done;
  logic [DATA_WIDTH-1:0] words [NREQ];

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .found      (pick_found),
    .index      (pick_idx)
  );

  always_comb begin
    for (int i = 0; i < NREQ; i++) words[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Outputs are gated by resetn so a reset cycle never writes or accepts.
  always_comb begin
    owner_valid  = req_valid[grant_id];
    busy         = resetn && (state == GRANT);
    xfer         = busy && owner_valid && !fifo_full;
    burst_done   = (beat_cnt == BCW'(BURST - 1));
    fifo_wr_en   = xfer;
    fifo_data_in = xfer ? words[grant_id] : '0;
    req_ready    = '0;
    if (busy) req_ready[grant_id] = !fifo_full;

    state_nxt = state;
    if (state == IDLE) begin
      if (pick_found) state_nxt = GRANT;
    end else begin
      if (!owner_valid || (xfer && burst_done)) state_nxt = IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= IDLE;
      grant_id   <= '0;
      beat_cnt   <= '0;
      last_grant <= IW'(NREQ - 1);
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (pick_found) grant_id <= pick_idx;
      end else if (state_nxt == IDLE) begin
        last_grant <= grant_id;
        beat_cnt   <= '0;
      end else if (xfer) begin
        beat_cnt <= beat_cnt + 1'b1;
      end
    end
  end

endmodule
